custom_ip_serializer: RTL and testbench
=======================================

# custom_ip_serializer

Transmit-side counterpart of the custom IP deserializer. It accepts even/odd byte pairs over a valid/ready handshake and emits frames on a 4-bit nibble line in the `clk_75mhz` domain. Each frame is a 16-bit sync header followed by `FRAME_GROUPS` groups of 4 nibbles. It sits between the pair-producing formatter and the 4-bit link driving the deserializer's `data_in`/`enable`.

## Interface
- `FRAME_GROUPS`, 324: pairs (groups) per frame; must be ≥1.
- `SYNC_WORD`, 16'hA5C3: header sent before every frame, MSB nibble first.
- `IDLE_NIBBLE`, 4'h0: `data_out` value whenever `data_out_valid`=0.
- `clk_75mhz` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: global run; 0 freezes the block.
- `c_even_data` in 8: even byte of the offered pair.
- `c_odd_data` in 8: odd byte of the offered pair.
- `pair_valid` in 1: pair offered.
- `pair_frame_start` in 1: offered pair is the first group of a frame.
- `pair_ready` out 1: pair accepted when `pair_valid && pair_ready`.
- `data_out` out 4: line nibble.
- `data_out_valid` out 1: nibble on `data_out` is meaningful (drives link enable).
- `tx_frame_start` out 1: pulse with first sync nibble.
- `tx_frame_end` out 1: pulse with last nibble of group `FRAME_GROUPS-1`.
- `drop_pulse` out 1: pulse when a pair is discarded in IDLE.

## Operation
- Storage: a one-entry holding buffer (`buf_valid`, 16 data bits, sof bit) plus a 16-bit shift register. The nibble index counts 0..3. The group counter is `$clog2(FRAME_GROUPS)` bits wide and counts 0..FRAME_GROUPS-1.
- `pair_ready = enable && (!buf_valid || buf_unload_this_cycle)`. This is combinational from registered state and `enable`, and does not depend on `pair_valid`.
- Group nibble order: `even[7:4]`, `even[3:0]`, `odd[7:4]`, `odd[3:0]`.
- States:
  - **IDLE**:
    - Outputs are idle.
    - If the buffer holds a pair with sof=1, unload it into the shift register and go to SYNC.
    - If the buffer holds a pair with sof=0, discard it, pulse `drop_pulse`, and stay in IDLE.
  - **SYNC**:
    - Emits the 4 `SYNC_WORD` nibbles on consecutive cycles.
    - `tx_frame_start` is asserted with nibble 0.
    - After nibble 3, go to DATA with nibble index 0 and group 0.
  - **DATA**:
    - Emits shift-register nibbles with `data_out_valid`=1.
    - At nibble 3 of group g<FRAME_GROUPS-1:
      - If `buf_valid`, unload the buffer and continue with group g+1. A buffered sof=1 inside a frame is treated as ordinary data.
      - Otherwise go to UNDERRUN.
    - At nibble 3 of the last group, assert `tx_frame_end`:
      - If `buf_valid` with sof=1, unload it and go to SYNC (back-to-back frame, no gap).
      - Otherwise go to IDLE. A sof=0 pair left in the buffer is then dropped in IDLE.
  - **UNDERRUN**:
    - `data_out_valid`=0 and `data_out=IDLE_NIBBLE`.
    - On the first cycle with `buf_valid`, unload and resume DATA at nibble 0 of the next group.
- `enable`=0: state, counters, buffer and shift register hold, and `pair_ready`=0. On the next edge the outputs become `data_out_valid`=0, `data_out=IDLE_NIBBLE`, and all pulses 0. Operation resumes exactly where it froze.
- Reset (asynchronous, any time, including mid-frame): state IDLE, `buf_valid`=0, counters 0. Outputs: `data_out=IDLE_NIBBLE`, `data_out_valid`=0, `tx_frame_start`=0, `tx_frame_end`=0, `drop_pulse`=0, `pair_ready`=0 while `rst_n`=0. A frame in progress is truncated, with no `tx_frame_end`.

## Timing
- All outputs except `pair_ready` are registered.
- A pair accepted at edge N with sof=1 from IDLE with an empty buffer:
  - Sync nibbles appear during cycles N+2..N+5: buffer at N+1, then unload.
  - `even[7:4]` appears at N+6.
- Sustained rate is one pair per 4 cycles. `pair_ready` drops once the buffer is full and reasserts in the cycle the buffer unloads.
- Full frame length with no stalls is 4 + 4·FRAME_GROUPS cycles of `data_out_valid`=1 (1300 for the default).
- Simultaneous unload and accept in the same cycle is legal. The buffer stays full with the new pair.

## Test plan
- **Single frame, FRAME_GROUPS=2.** Pairs (A1,B2) with sof=1, then (C3,D4).
  - Line shows A,5,C,3,A,1,B,2,C,3,D,4 with valid=1.
  - `tx_frame_start` pulses on the first A and `tx_frame_end` on the 4.
  - Then idle 0.
- **Underrun.** Delay the second pair by 10 cycles after the first group.
  - `data_out_valid`=0 for the gap, then the group resumes at `even[7:4]`.
  - Total valid nibbles are 12.
- **Back-to-back frames.** Two sof frames with continuous `pair_valid`.
  - The second frame's sync immediately follows the first frame's last nibble, with no valid=0 gap.
  - `pair_ready` duty is 1 in 4 in steady state.
- **Drop.** Offer a sof=0 pair in IDLE.
  - `drop_pulse` pulses once and no line activity follows.
  - A subsequent sof=1 pair then starts a frame normally.
- **Enable freeze.** Drop `enable` for 5 cycles mid-group.
  - valid=0 and ready=0 for those cycles.
  - The nibble sequence resumes unchanged.
- **Reset mid-frame.** Assert `rst_n`=0 at group 100 of 324.
  - Outputs go to reset values immediately, with no `tx_frame_end`.
  - A new sof pair after release produces a full 1300-nibble frame.

Source files
------------

// File: rtl/custom_ip_serializer_if.sv
// Pair handshake from the formatter plus the nibble line toward the deserializer.
// The serializer is the slave: it consumes pairs and drives the line.
`timescale 1ns/1ps
interface custom_ip_serializer_if;
  logic [7:0] c_even_data;
  logic [7:0] c_odd_data;
  logic       pair_valid;
  logic       pair_frame_start;
  logic       pair_ready;
  logic [3:0] data_out;
  logic       data_out_valid;
  logic       tx_frame_start;
  logic       tx_frame_end;
  logic       drop_pulse;

  modport master (
    output c_even_data, c_odd_data, pair_valid, pair_frame_start,
    input  pair_ready, data_out, data_out_valid, tx_frame_start, tx_frame_end, drop_pulse
  );

  modport slave (
    input  c_even_data, c_odd_data, pair_valid, pair_frame_start,
    output pair_ready, data_out, data_out_valid, tx_frame_start, tx_frame_end, drop_pulse
  );
endinterface

// File: rtl/custom_ip_serializer.sv
// Frames even/odd byte pairs onto a 4-bit line: 16-bit sync header, then
// FRAME_GROUPS groups of 4 nibbles, fed through a one-entry holding buffer.
`timescale 1ns/1ps
module custom_ip_serializer #(
  parameter int         FRAME_GROUPS = 324,
  parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
  parameter logic [3:0]  IDLE_NIBBLE = 4'h0
) (
  input  logic              clk_75mhz,
  input  logic              rst_n,
  input  logic              enable,
  custom_ip_serializer_if.slave pair_if
);

  localparam int GW = (FRAME_GROUPS > 1) ? $clog2(FRAME_GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GROUP = GW'(FRAME_GROUPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_UNDERRUN} state_t;

  state_t        state;
  logic          buf_valid;
  logic          buf_sof;
  logic [15:0]   buf_data;
  logic [15:0]   shreg;
  logic [1:0]    nib;
  logic [GW-1:0] grp;

  logic          unload;
  logic          drop;
  logic          accept;
  logic [3:0]    sync_nib;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    unload   = 1'b0;
    drop     = 1'b0;
    sync_nib = SYNC_WORD[15:12];
    case (nib)
      2'd0:    sync_nib = SYNC_WORD[15:12];
      2'd1:    sync_nib = SYNC_WORD[11:8];
      2'd2:    sync_nib = SYNC_WORD[7:4];
      default: sync_nib = SYNC_WORD[3:0];
    endcase
    if (enable) begin
      case (state)
        S_IDLE: begin
          unload = buf_valid && buf_sof;
          drop   = buf_valid && !buf_sof;
        end
        // Mid-frame any pair continues the frame; after the last group only a sof pair chains.
        S_DATA:     if (nib == 2'd3) unload = buf_valid && ((grp != LAST_GROUP) || buf_sof);
        S_UNDERRUN: unload = buf_valid;
        default:    ;
      endcase
    end
  end

  // A drop frees the buffer just like an unload, so either lets a new pair in.
  assign pair_if.pair_ready = rst_n && enable && (!buf_valid || unload || drop);
  assign accept             = pair_if.pair_valid && pair_if.pair_ready;

  always_ff @(posedge clk_75mhz or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too; they are few and it keeps the line X-free.
      state                  <= S_IDLE;
      buf_valid              <= 1'b0;
      buf_sof                <= 1'b0;
      buf_data               <= '0;
      shreg                  <= '0;
      nib                    <= '0;
      grp                    <= '0;
      pair_if.data_out       <= IDLE_NIBBLE;
      pair_if.data_out_valid <= 1'b0;
      pair_if.tx_frame_start <= 1'b0;
      pair_if.tx_frame_end   <= 1'b0;
      pair_if.drop_pulse     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values.
      if (accept) begin
        buf_valid <= 1'b1;
        buf_sof   <= pair_if.pair_frame_start;
        buf_data  <= {pair_if.c_even_data, pair_if.c_odd_data};
      end else if (unload || drop) begin
        buf_valid <= 1'b0;
      end

      pair_if.data_out       <= IDLE_NIBBLE;
      pair_if.data_out_valid <= 1'b0;
      pair_if.tx_frame_start <= 1'b0;
      pair_if.tx_frame_end   <= 1'b0;
      pair_if.drop_pulse     <= 1'b0;

      if (enable) begin
        case (state)
          S_IDLE: begin
            pair_if.drop_pulse <= drop;
            if (unload) begin
              shreg <= buf_data;
              nib   <= '0;
              state <= S_SYNC;
            end
          end
          S_SYNC: begin
            pair_if.data_out       <= sync_nib;
            pair_if.data_out_valid <= 1'b1;
            pair_if.tx_frame_start <= (nib == 2'd0);
            nib                    <= nib + 2'd1;
            if (nib == 2'd3) begin
              grp   <= '0;
              state <= S_DATA;
            end
          end
          S_DATA: begin
            pair_if.data_out       <= shreg[15:12];
            pair_if.data_out_valid <= 1'b1;
            shreg                  <= {shreg[11:0], 4'h0};
            nib                    <= nib + 2'd1;
            if (nib == 2'd3) begin
              if (grp != LAST_GROUP) begin
                if (unload) begin
                  shreg <= buf_data;
                  grp   <= grp + 1'b1;
                end else begin
                  state <= S_UNDERRUN;
                end
              end else begin
                pair_if.tx_frame_end <= 1'b1;
                if (unload) begin
                  shreg <= buf_data;
                  state <= S_SYNC;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
          end
          S_UNDERRUN: begin
            if (unload) begin
              shreg <= buf_data;
              grp   <= grp + 1'b1;
              nib   <= '0;
              state <= S_DATA;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_custom_ip_serializer.sv
// Self-checking bench: a 2-group instance checked nibble by nibble against a
// scoreboard, plus a 324-group instance for mid-frame reset and full frame length.
`timescale 1ns/1ps
module tb_custom_ip_serializer;

  localparam int          G_SMALL = 2;
  localparam int          G_BIG   = 324;
  localparam logic [15:0] SYNC    = 16'hA5C3;
  localparam logic [3:0]  IDLE_N  = 4'h0;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic rst_n_b = 1'b1;
  logic enable  = 1'b1;
  logic en_b    = 1'b1;
  always #5 clk = ~clk;

  custom_ip_serializer_if s_if ();
  custom_ip_serializer_if b_if ();

  custom_ip_serializer #(.FRAME_GROUPS(G_SMALL), .SYNC_WORD(16'hA5C3), .IDLE_NIBBLE(4'h0)) dut_small (
    .clk_75mhz(clk), .rst_n(rst_n), .enable(enable), .pair_if(s_if.slave));

  custom_ip_serializer #(.FRAME_GROUPS(G_BIG), .SYNC_WORD(16'hA5C3), .IDLE_NIBBLE(4'h0)) dut_big (
    .clk_75mhz(clk), .rst_n(rst_n_b), .enable(en_b), .pair_if(b_if.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard and reference model (small instance) ----------------
  typedef struct { logic [3:0] nib; logic start; logic fend; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  bit   m_in_frame = 1'b0;
  int   m_grp      = 0;
  int   exp_drops  = 0;

  function automatic void model_pair(input logic sof, input logic [15:0] line);
    logic [15:0] sw;
    sw = SYNC;
    if (!m_in_frame) begin
      if (!sof) begin
        exp_drops++;
        return;
      end
      for (int k = 0; k < 4; k++) exp_q.push_back('{sw[15-4*k -: 4], (k == 0), 1'b0});
      m_grp      = 0;
      m_in_frame = 1'b1;
    end else begin
      m_grp++;
    end
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{line[15-4*k -: 4], 1'b0, (k == 3) && (m_grp == G_SMALL - 1)});
    if (m_grp == G_SMALL - 1) m_in_frame = 1'b0;
  endfunction

  // ---------------- small-instance monitor ----------------
  int  s_valid_cnt = 0, drop_cnt = 0, b2b_cnt = 0, cur_len = 0, cur_gap = 0;
  bit  in_frame = 1'b0, prev_end = 1'b0;
  int  frame_len[$];
  int  frame_gap[$];
  time start_ts[$];

  always @(negedge clk) begin
    if (s_if.drop_pulse) drop_cnt++;
    if (s_if.tx_frame_start) begin
      if (prev_end) b2b_cnt++;
      in_frame = 1'b1;
      cur_len  = 0;
      cur_gap  = 0;
      start_ts.push_back($time);
    end
    if (s_if.data_out_valid) begin
      s_valid_cnt++;
      if (in_frame) cur_len++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_extra_nibble: got %0h with nothing expected at %0t", s_if.data_out, $time);
      end else begin
        e = exp_q.pop_front();
        check("line_nibble", 32'({s_if.tx_frame_start, s_if.tx_frame_end, s_if.data_out}),
              32'({e.start, e.fend, e.nib}));
      end
    end else begin
      check("idle_line", 32'({s_if.data_out, s_if.tx_frame_start, s_if.tx_frame_end}),
            32'({IDLE_N, 2'b00}));
      if (in_frame) cur_gap++;
    end
    if (s_if.tx_frame_end) begin
      frame_len.push_back(cur_len);
      frame_gap.push_back(cur_gap);
      in_frame = 1'b0;
    end
    prev_end = s_if.tx_frame_end;
  end

  // ---------------- big-instance monitor ----------------
  int b_valid_cnt = 0, b_end_cnt = 0, b_start_cnt = 0;
  always @(negedge clk) begin
    if (b_if.data_out_valid) b_valid_cnt++;
    if (b_if.tx_frame_end)   b_end_cnt++;
    if (b_if.tx_frame_start) b_start_cnt++;
  end

  // ---------------- drivers ----------------
  task automatic send_small(input logic sof, input logic [7:0] ev, input logic [7:0] od,
                            input int gap, input logic [15:0] exp_line, output time t_acc);
    int tries;
    t_acc = 0;
    @(negedge clk);
    if (gap > 0) begin
      s_if.pair_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_if.c_even_data      = ev;
    s_if.c_odd_data       = od;
    s_if.pair_frame_start = sof;
    s_if.pair_valid       = 1'b1;
    tries = 0;
    while (!s_if.pair_ready && tries < 300) begin
      @(negedge clk);
      tries++;
    end
    if (!s_if.pair_ready) begin
      check("small_ready_timeout", 32'(s_if.pair_ready), 32'd1);
      s_if.pair_valid = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    model_pair(sof, exp_line);
  endtask

  task automatic send_big(input logic sof, input logic [7:0] ev, input logic [7:0] od);
    int tries;
    @(negedge clk);
    b_if.c_even_data      = ev;
    b_if.c_odd_data       = od;
    b_if.pair_frame_start = sof;
    b_if.pair_valid       = 1'b1;
    tries = 0;
    while (!b_if.pair_ready && tries < 300) begin
      @(negedge clk);
      tries++;
    end
    if (!b_if.pair_ready) begin
      check("big_ready_timeout", 32'(b_if.pair_ready), 32'd1);
      b_if.pair_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic wait_drain();
    int t;
    @(negedge clk);
    s_if.pair_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sof;
    logic [7:0]  ev;
    logic [7:0]  od;
    int          gap;
    bit          wait_idle;
    logic [15:0] exp_line;
  } vec_t;
  vec_t vecs[8];

  initial begin
    time acc[8];
    time t_dummy;
    int  v0, bv0, be0, bs0;
    int  t;

    vecs[0] = '{1'b1, 8'hA1, 8'hB2, 0,  1'b1, 16'hA1B2};  // single frame
    vecs[1] = '{1'b0, 8'hC3, 8'hD4, 0,  1'b0, 16'hC3D4};
    vecs[2] = '{1'b1, 8'h11, 8'h22, 0,  1'b1, 16'h1122};  // underrun
    vecs[3] = '{1'b0, 8'h33, 8'h44, 10, 1'b0, 16'h3344};
    vecs[4] = '{1'b1, 8'h5A, 8'h6B, 0,  1'b1, 16'h5A6B};  // back-to-back
    vecs[5] = '{1'b0, 8'h7C, 8'h8D, 0,  1'b0, 16'h7C8D};
    vecs[6] = '{1'b1, 8'h9E, 8'hAF, 0,  1'b0, 16'h9EAF};
    vecs[7] = '{1'b0, 8'hF0, 8'h0F, 0,  1'b0, 16'hF00F};

    s_if.pair_valid = 1'b0; s_if.pair_frame_start = 1'b0; s_if.c_even_data = '0; s_if.c_odd_data = '0;
    b_if.pair_valid = 1'b0; b_if.pair_frame_start = 1'b0; b_if.c_even_data = '0; b_if.c_odd_data = '0;

    // Reset state
    #1;
    rst_n   = 1'b0;
    rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",     32'(s_if.pair_ready), 32'd0);
    check("rst_valid",     32'(s_if.data_out_valid), 32'd0);
    check("rst_data",      32'(s_if.data_out), 32'(IDLE_N));
    check("rst_pulses",    32'({s_if.tx_frame_start, s_if.tx_frame_end, s_if.drop_pulse}), 32'd0);
    check("rst_big_ready", 32'(b_if.pair_ready), 32'd0);
    rst_n   = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(s_if.pair_ready), 32'd1);

    // Table: single frame, underrun, back-to-back
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wait_idle) wait_drain();
      send_small(vecs[i].sof, vecs[i].ev, vecs[i].od, vecs[i].gap, vecs[i].exp_line, acc[i]);
    end
    wait_drain();

    check("frame_count", 32'(frame_len.size()), 32'd4);
    if (frame_len.size() == 4) begin
      for (int i = 0; i < 4; i++) check("frame_len", 32'(frame_len[i]), 32'd12);
      check("single_gap",    32'(frame_gap[0]), 32'd0);
      check("underrun_gap",  32'(frame_gap[1]), 32'd3);
      check("b2b_gap_f1",    32'(frame_gap[2]), 32'd0);
      check("b2b_gap_f2",    32'(frame_gap[3]), 32'd0);
      check("first_latency", 32'(start_ts[0] - acc[0]), 32'd25);
    end
    check("b2b_chained",   32'(b2b_cnt), 32'd1);
    check("steady_rate",   32'(acc[7] - acc[6]), 32'd40);

    // Drop in IDLE, then a normal frame
    v0 = s_valid_cnt;
    send_small(1'b0, 8'h12, 8'h34, 0, 16'h1234, t_dummy);
    wait_drain();
    repeat (6) @(negedge clk);
    check("drop_once",      32'(drop_cnt), 32'(exp_drops));
    check("drop_no_line",   32'(s_valid_cnt - v0), 32'd0);
    send_small(1'b1, 8'h5E, 8'h6F, 0, 16'h5E6F, t_dummy);
    send_small(1'b0, 8'h70, 8'h81, 0, 16'h7081, t_dummy);
    wait_drain();
    check("after_drop_frames", 32'(frame_len.size()), 32'd5);
    if (frame_len.size() == 5) check("after_drop_len", 32'(frame_len[4]), 32'd12);

    // Enable freeze in the middle of group 1
    send_small(1'b1, 8'hC1, 8'hD2, 0, 16'hC1D2, t_dummy);
    send_small(1'b0, 8'hE3, 8'hF4, 0, 16'hE3F4, t_dummy);
    @(negedge clk);
    s_if.pair_valid = 1'b0;
    repeat (9) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("freeze_valid", 32'(s_if.data_out_valid), 32'd0);
      check("freeze_ready", 32'(s_if.pair_ready), 32'd0);
    end
    enable = 1'b1;
    wait_drain();
    check("freeze_frames", 32'(frame_len.size()), 32'd6);
    if (frame_len.size() == 6) begin
      check("freeze_len", 32'(frame_len[5]), 32'd12);
      check("freeze_gap", 32'(frame_gap[5]), 32'd5);
    end

    // Reset mid-frame on the full-size instance
    bv0 = b_valid_cnt;
    be0 = b_end_cnt;
    send_big(1'b1, 8'h00, 8'h01);
    for (int k = 1; k <= 101; k++) send_big(1'b0, 8'(k), 8'(k + 1));
    repeat (2) @(negedge clk);
    #2;
    rst_n_b = 1'b0;
    b_if.pair_valid = 1'b0;
    #1;
    check("midrst_valid", 32'(b_if.data_out_valid), 32'd0);
    check("midrst_data",  32'(b_if.data_out), 32'(IDLE_N));
    check("midrst_pulse", 32'({b_if.tx_frame_start, b_if.tx_frame_end, b_if.drop_pulse}), 32'd0);
    check("midrst_ready", 32'(b_if.pair_ready), 32'd0);
    check("midrst_nibs",  32'(b_valid_cnt - bv0), 32'd405);
    check("midrst_noend", 32'(b_end_cnt - be0), 32'd0);
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1;

    bv0 = b_valid_cnt;
    be0 = b_end_cnt;
    bs0 = b_start_cnt;
    send_big(1'b1, 8'h3C, 8'hC3);
    for (int k = 1; k < G_BIG; k++) send_big(1'b0, 8'(k), 8'(255 - k));
    @(negedge clk);
    b_if.pair_valid = 1'b0;
    t = 0;
    while (b_end_cnt == be0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("full_frame_nibs",  32'(b_valid_cnt - bv0), 32'd1300);
    check("full_frame_end",   32'(b_end_cnt - be0), 32'd1);
    check("full_frame_start", 32'(b_start_cnt - bs0), 32'd1);

    check("drop_total", 32'(drop_cnt), 32'(exp_drops));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
